// File: rtl/ray_column_scheduler.sv
// Column scheduler for a raycaster: snapshots the camera once per frame, then
// issues each screen column to the ray unit and retires it on a FIFO handshake.
module ray_column_scheduler #(
  parameter int SCREEN_WIDTH   = 320,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        frame_start_in,
  input  logic [15:0] posX_in,
  input  logic [15:0] posY_in,
  input  logic [15:0] dirX_in,
  input  logic [15:0] dirY_in,
  input  logic [15:0] planeX_in,
  input  logic [15:0] planeY_in,
  output logic [15:0] posX_out,
  output logic [15:0] posY_out,
  output logic [15:0] dirX_out,
  output logic [15:0] dirY_out,
  output logic [15:0] planeX_out,
  output logic [15:0] planeY_out,
  output logic [8:0]  hcount_out,
  output logic        tabulate_out,
  input  logic        ray_valid_in,
  input  logic        fifo_ready_in,
  output logic        ray_ready_out,
  output logic        busy_out,
  output logic        frame_done_out,
  output logic        timeout_err_out
);

  localparam int              TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [8:0]      LAST_COL  = 9'(SCREEN_WIDTH - 1);
  localparam logic [TW-1:0]   TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RAY,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [8:0]    hcount_q;
  logic [TW-1:0] timer_q;
  logic          tabulate_q;
  logic          frame_done_q;
  logic          timeout_err_q;
  logic [15:0]   posx_q, posy_q, dirx_q, diry_q, planex_q, planey_q;
  logic          transfer;

  assign ray_ready_out = (state_q == S_WAIT_RAY) && fifo_ready_in;
  assign transfer      = ray_valid_in && ray_ready_out;
  assign busy_out      = (state_q != S_IDLE);

  // tabulate_q and frame_done_q are raised on the edge that enters ISSUE/DONE,
  // so each pulse lines up exactly with the one cycle spent in that state.
  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // below reads the pre-edge values regardless of statement order.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      hcount_q      <= '0;
      timer_q       <= '0;
      tabulate_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      posx_q        <= '0;
      posy_q        <= '0;
      dirx_q        <= '0;
      diry_q        <= '0;
      planex_q      <= '0;
      planey_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_start_in) begin
            posx_q     <= posX_in;
            posy_q     <= posY_in;
            dirx_q     <= dirX_in;
            diry_q     <= dirY_in;
            planex_q   <= planeX_in;
            planey_q   <= planeY_in;
            hcount_q   <= '0;
            tabulate_q <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tabulate_q <= 1'b0;
          timer_q    <= '0;
          state_q    <= S_WAIT_RAY;
        end
        S_WAIT_RAY: begin
          if (transfer) begin
            if (hcount_q == LAST_COL) begin
              frame_done_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              hcount_q   <= hcount_q + 9'd1;
              tabulate_q <= 1'b1;
              state_q    <= S_ISSUE;
            end
          end else if (!ray_valid_in) begin
            // Silent ray unit: reissue the same column once the budget runs out.
            if (timer_q == TIMER_MAX) begin
              timeout_err_q <= 1'b1;
              tabulate_q    <= 1'b1;
              state_q       <= S_ISSUE;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
        end
        S_DONE: begin
          frame_done_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign posX_out        = posx_q;
  assign posY_out        = posy_q;
  assign dirX_out        = dirx_q;
  assign dirY_out        = diry_q;
  assign planeX_out      = planex_q;
  assign planeY_out      = planey_q;
  assign hcount_out      = hcount_q;
  assign tabulate_out    = tabulate_q;
  assign frame_done_out  = frame_done_q;
  assign timeout_err_out = timeout_err_q;

endmodule

// File: tb/tb_ray_column_scheduler.sv
// Directed bench for ray_column_scheduler with a 4-column screen: nominal frame,
// backpressure, timeout reissue, parameter snapshot and mid-frame reset.
module tb_ray_column_scheduler;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        frame_start_in;
  logic [15:0] posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in;
  logic [15:0] posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out;
  logic [8:0]  hcount_out;
  logic        tabulate_out;
  logic        ray_valid_in;
  logic        fifo_ready_in;
  logic        ray_ready_out;
  logic        busy_out;
  logic        frame_done_out;
  logic        timeout_err_out;

  int checks = 0;
  int errors = 0;
  int tab_count = 0;
  int done_count = 0;

  ray_column_scheduler #(.SCREEN_WIDTH(4), .TIMEOUT_CYCLES(64)) dut (
    .pixel_clk_in   (clk),
    .rst_in         (rst_in),
    .frame_start_in (frame_start_in),
    .posX_in        (posX_in),
    .posY_in        (posY_in),
    .dirX_in        (dirX_in),
    .dirY_in        (dirY_in),
    .planeX_in      (planeX_in),
    .planeY_in      (planeY_in),
    .posX_out       (posX_out),
    .posY_out       (posY_out),
    .dirX_out       (dirX_out),
    .dirY_out       (dirY_out),
    .planeX_out     (planeX_out),
    .planeY_out     (planeY_out),
    .hcount_out     (hcount_out),
    .tabulate_out   (tabulate_out),
    .ray_valid_in   (ray_valid_in),
    .fifo_ready_in  (fifo_ready_in),
    .ray_ready_out  (ray_ready_out),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out),
    .timeout_err_out(timeout_err_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tabulate_out)   tab_count++;
    if (frame_done_out) done_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tab();
    logic found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tabulate_out) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("tabulate_wait", 16'(found), 16'd1);
  endtask

  // Ray unit model: answers 3 cycles after tabulate and holds valid until accepted.
  task automatic serve(input logic [8:0] col);
    logic found = 1'b0;
    wait_tab();
    chk("tab_hcount", 16'(hcount_out), 16'(col));
    repeat (3) tick();
    ray_valid_in = 1'b1;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (ray_ready_out) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("ready_wait", 16'(found), 16'd1);
    tick();
    ray_valid_in = 1'b0;
  endtask

  task automatic start_frame();
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_posX"},   posX_out,   16'h0);
    chk({tag, "_posY"},   posY_out,   16'h0);
    chk({tag, "_dirX"},   dirX_out,   16'h0);
    chk({tag, "_dirY"},   dirY_out,   16'h0);
    chk({tag, "_planeX"}, planeX_out, 16'h0);
    chk({tag, "_planeY"}, planeY_out, 16'h0);
    chk({tag, "_hcount"}, 16'(hcount_out),      16'h0);
    chk({tag, "_tab"},    16'(tabulate_out),    16'h0);
    chk({tag, "_done"},   16'(frame_done_out),  16'h0);
    chk({tag, "_terr"},   16'(timeout_err_out), 16'h0);
    chk({tag, "_ready"},  16'(ray_ready_out),   16'h0);
    chk({tag, "_busy"},   16'(busy_out),        16'h0);
  endtask

  initial begin
    int  gap;
    logic any_ready;
    rst_in = 1'b1;
    frame_start_in = 1'b0;
    ray_valid_in = 1'b0;
    fifo_ready_in = 1'b1;
    posX_in = 16'h0180; posY_in = 16'h0240; dirX_in = 16'hFF00;
    dirY_in = 16'h0000; planeX_in = 16'h0000; planeY_in = 16'h00A8;
    #1;
    check_all_zero("reset");
    repeat (2) tick();
    rst_in = 1'b0;
    tick();

    // Ray valid while idle is not accepted.
    ray_valid_in = 1'b1;
    #1;
    chk("idle_ready", 16'(ray_ready_out), 16'd0);
    tick();
    ray_valid_in = 1'b0;

    // Nominal frame.
    start_frame();
    chk("latency_tab", 16'(tabulate_out), 16'd1);
    chk("busy_frame", 16'(busy_out), 16'd1);
    chk("snap_posX", posX_out, 16'h0180);
    chk("snap_posY", posY_out, 16'h0240);
    chk("snap_dirX", dirX_out, 16'hFF00);
    chk("snap_dirY", dirY_out, 16'h0000);
    chk("snap_planeX", planeX_out, 16'h0000);
    chk("snap_planeY", planeY_out, 16'h00A8);
    for (int c = 0; c < 4; c++) serve(9'(c));
    chk("done_pulse", 16'(frame_done_out), 16'd1);
    tick();
    chk("done_single", 16'(frame_done_out), 16'd0);
    chk("busy_after", 16'(busy_out), 16'd0);
    chk("hcount_hold", 16'(hcount_out), 16'd3);
    chk("nom_tab_count", 16'(tab_count), 16'd4);
    chk("nom_done_count", 16'(done_count), 16'd1);
    chk("nom_no_terr", 16'(timeout_err_out), 16'd0);

    // Backpressure on column 2.
    start_frame();
    serve(9'd0);
    serve(9'd1);
    wait_tab();
    chk("bp_hcount", 16'(hcount_out), 16'd2);
    repeat (3) tick();
    ray_valid_in = 1'b1;
    fifo_ready_in = 1'b0;
    any_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (ray_ready_out) any_ready = 1'b1;
      tick();
    end
    chk("bp_no_ready", 16'(any_ready), 16'd0);
    chk("bp_no_terr", 16'(timeout_err_out), 16'd0);
    chk("bp_hcount_hold", 16'(hcount_out), 16'd2);
    chk("bp_no_reissue", 16'(tabulate_out), 16'd0);
    fifo_ready_in = 1'b1;
    #1;
    chk("bp_ready", 16'(ray_ready_out), 16'd1);
    tick();
    ray_valid_in = 1'b0;
    chk("bp_next_tab", 16'(tabulate_out), 16'd1);
    chk("bp_next_col", 16'(hcount_out), 16'd3);
    serve(9'd3);
    chk("bp_done", 16'(frame_done_out), 16'd1);
    tick();

    // Timeout on column 1: 1 ISSUE cycle + 64 WAIT_RAY cycles before reissue.
    start_frame();
    serve(9'd0);
    wait_tab();
    chk("to_hcount", 16'(hcount_out), 16'd1);
    gap = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      gap++;
      if (gap == 64) chk("to_not_yet", 16'(timeout_err_out), 16'd0);
      if (tabulate_out) break;
    end
    chk("to_gap", 16'(gap), 16'd65);
    chk("to_terr", 16'(timeout_err_out), 16'd1);
    chk("to_reissue_col", 16'(hcount_out), 16'd1);
    for (int c = 1; c < 4; c++) serve(9'(c));
    chk("to_done", 16'(frame_done_out), 16'd1);
    tick();
    chk("to_sticky", 16'(timeout_err_out), 16'd1);
    chk("to_tab_count", 16'(tab_count), 16'd13);

    // Snapshot stability and ignored mid-frame start.
    start_frame();
    serve(9'd0);
    posX_in = 16'h0200;
    tick();
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    chk("snap_hold", posX_out, 16'h0180);
    chk("mid_start_col", 16'(hcount_out), 16'd1);
    for (int c = 1; c < 4; c++) serve(9'(c));
    tick();
    chk("snap_after_frame", posX_out, 16'h0180);
    start_frame();
    chk("snap_new", posX_out, 16'h0200);

    // Asynchronous reset partway through column 2.
    serve(9'd0);
    serve(9'd1);
    wait_tab();
    tick();
    gap = done_count;
    #2;
    rst_in = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    rst_in = 1'b0;
    repeat (3) tick();
    chk("rst_no_done", 16'(done_count), 16'(gap));
    start_frame();
    chk("rst_restart_tab", 16'(tabulate_out), 16'd1);
    chk("rst_restart_col", 16'(hcount_out), 16'd0);
    chk("rst_restart_snap", posX_out, 16'h0200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ray_column_scheduler.md
RAY_COLUMN_SCHEDULER -- requirements
Module: ray_column_scheduler

Interface
REQ-001 Parameter SCREEN_WIDTH, default 320: number of screen columns (rays) issued per frame.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: maximum WAIT_RAY cycles with no ray_valid_in before the column is reissued.
REQ-003 Port pixel_clk_in, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_in, input, 1: reset; asynchronous, active-high.
REQ-005 Port frame_start_in, input, 1: single-cycle request to render one frame.
REQ-006 Ports posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in, input, 16 each: live camera parameters (Q8.8) from the player controller.
REQ-007 Ports posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out, output, 16 each: frame-stable parameter snapshot driven to the ray calculation unit.
REQ-008 Port hcount_out, output, 9: column currently being calculated.
REQ-009 Port tabulate_out, output, 1: single-cycle start pulse to the ray calculation unit.
REQ-010 Port ray_valid_in, input, 1: ray calculation unit has a finished ray for hcount_out.
REQ-011 Port fifo_ready_in, input, 1: downstream DDA FIFO can accept a ray.
REQ-012 Port ray_ready_out, output, 1: acceptance, wired to the ray unit's dda_data_ready_out.
REQ-013 Port busy_out, output, 1: high whenever state is not IDLE.
REQ-014 Port frame_done_out, output, 1: single-cycle pulse after the last column transfers.
REQ-015 Port timeout_err_out, output, 1: sticky flag, set when any column timed out.

Function
REQ-016 State machine states: IDLE, ISSUE, WAIT_RAY, DONE; all outputs except ray_ready_out and busy_out are registered.
REQ-017 IDLE: on frame_start_in=1, latch all six *_in parameters into *_out, set hcount_out=0, go to ISSUE.
REQ-018 Parameter snapshot changes only on the IDLE frame_start_in edge; *_in changes mid-frame have no effect on *_out.
REQ-019 ISSUE: tabulate_out=1 for exactly that one cycle, wait timer cleared to 0, next state WAIT_RAY.
REQ-020 Latency: frame_start_in sampled at edge k -> tabulate_out high during the cycle following edge k.
REQ-021 ray_ready_out = (state==WAIT_RAY) AND fifo_ready_in, combinational; a transfer is ray_valid_in AND ray_ready_out.
REQ-022 WAIT_RAY on transfer: if hcount_out==SCREEN_WIDTH-1 go to DONE, else hcount_out+1 and go to ISSUE.
REQ-023 WAIT_RAY, ray_valid_in=0: wait timer increments; at TIMEOUT_CYCLES-1 set timeout_err_out=1 and go to ISSUE with hcount_out unchanged (reissue).
REQ-024 WAIT_RAY, ray_valid_in=1 and fifo_ready_in=0: backpressure; timer holds, no timeout, state holds.
REQ-025 DONE: frame_done_out=1 for exactly one cycle, next state IDLE; hcount_out holds SCREEN_WIDTH-1.
REQ-026 frame_start_in while not IDLE is ignored (no restart, no queueing, snapshot unchanged).
REQ-027 ray_valid_in outside WAIT_RAY is ignored; ray_ready_out stays 0.
REQ-028 hcount_out never exceeds SCREEN_WIDTH-1; timer is ceil(log2(TIMEOUT_CYCLES)) bits and never wraps.
REQ-029 timeout_err_out clears only on reset.

Reset
REQ-030 rst_in=1 immediately (asynchronously) forces state IDLE, hcount_out=0, timer=0, all *_out parameters=0, tabulate_out=0, frame_done_out=0, timeout_err_out=0; ray_ready_out and busy_out=0.
REQ-031 Reset mid-frame abandons the frame with no frame_done_out; the first frame_start_in after release starts a fresh frame at column 0.

Verification
REQ-032 Nominal: SCREEN_WIDTH=4, ray model returns valid 3 cycles after tabulate, fifo_ready_in=1 -> exactly 4 tabulate pulses with hcount 0,1,2,3, one frame_done_out, busy_out low after.
REQ-033 Backpressure: fifo_ready_in=0 for 100 cycles while ray_valid_in=1 on column 2 -> ray_ready_out=0, no timeout, hcount stays 2; transfer on first ready cycle.
REQ-034 Timeout: ray model silent for column 1 -> timeout_err_out=1 after 64 WAIT_RAY cycles, second tabulate pulse with hcount_out=1, frame still completes.
REQ-035 Snapshot: posX_in changes 0x0180->0x0200 mid-frame -> posX_out stays 0x0180 until next frame_start_in; frame_start_in mid-frame ignored.
REQ-036 Reset: assert rst_in mid-column 2 between clock edges -> all outputs zero before next edge; no frame_done_out; next frame_start_in yields tabulate with hcount_out=0.
